// File: rtl/hex_reg_overlay.sv
// rtl/hex_reg_overlay.sv - VGA text overlay drawing NUM_REGS rows "R<i>=<hex>" from a per-frame register snapshot
//
// Purpose: sits between the VGA timing generator and the RGB pins. It decodes the pixel position into a
// character cell, addresses the external clocked ASCII ROM, and colours glyph pixels. Rows whose value
// changed at the last snapshot are drawn in a highlight colour for HOLD_FRAMES frames.
//
// Ports:
//   clkvga    in   pixel clock, the only clock
//   rst_n     in   asynchronous active-low reset
//   video_on  in   active-video flag from the timing generator
//   x, y      in   current pixel column / line
//   reg_flat  in   register values, reg i at [i*DATA_W +: DATA_W]
//   rom_addr  out  {ascii[6:0], glyph_row[3:0]} to the ASCII ROM
//   rom_data  in   glyph row from the ROM, bit 7 = leftmost pixel
//   rgb       out  pixel colour, ROM_LAT+2 cycles after x/y/video_on
module hex_reg_overlay #(
  parameter int          NUM_REGS    = 8,
  parameter int          DATA_W      = 8,
  parameter int          ORIGIN_X    = 192,
  parameter int          ORIGIN_Y    = 208,
  parameter int          SNAP_LINE   = 480,
  parameter int          HOLD_FRAMES = 60,
  parameter int          ROM_LAT     = 1,
  parameter logic [11:0] FG_RGB      = 12'h00F,
  parameter logic [11:0] HL_RGB      = 12'hF00,
  parameter logic [11:0] BG_RGB      = 12'hFFF
) (
  input  logic                       clkvga,
  input  logic                       rst_n,
  input  logic                       video_on,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
  output logic [10:0]                rom_addr,
  input  logic [7:0]                 rom_data,
  output logic [11:0]                rgb
);
  localparam int HEX_DIG = DATA_W / 4;
  localparam int COLS    = 3 + HEX_DIG;
  localparam int WIN_W   = COLS * 8;
  localparam int WIN_H   = NUM_REGS * 16;
  localparam int HC_W    = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  function automatic logic [6:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (7'h30 + {3'b000, n}) : (7'h37 + {3'b000, n});
  endfunction

  logic [11:0]         w_dx, w_dy;
  logic                w_in_win, w_snap, w_hl, w_px;
  logic [7:0]          w_col;
  logic [3:0]          w_row, w_nib;
  logic [DATA_W-1:0]   w_val;
  logic [HC_W-1:0]     w_hc;
  logic [6:0]          w_char;

  logic [NUM_REGS*DATA_W-1:0] r_shadow, r_prev;
  logic [HC_W-1:0]            r_hc [NUM_REGS];
  logic                       r_snap_d;
  logic [10:0]                r_rom_addr;
  logic [2:0]                 r_bit [ROM_LAT+1];
  logic [ROM_LAT:0]           r_win, r_hl, r_von;
  logic [11:0]                r_rgb;

  // 12-bit two's-complement offsets: positions left of / above the window come out negative
  // (bit 11 set) instead of wrapping into it.
  assign w_dx     = {2'b00, x} - 12'(ORIGIN_X);
  assign w_dy     = {2'b00, y} - 12'(ORIGIN_Y);
  assign w_in_win = !w_dx[11] && (w_dx < 12'(WIN_W)) && !w_dy[11] && (w_dy < 12'(WIN_H));
  assign w_col    = w_dx[10:3];
  assign w_row    = w_dy[7:4];
  assign w_snap   = (x == 10'd0) && (y == 10'(SNAP_LINE));

  // Row and nibble selection by compare loops keeps every index a constant.
  always_comb begin
    w_val  = '0;
    w_hc   = '0;
    w_nib  = '0;
    w_char = 7'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_row == 4'(i)) begin
        w_val = r_shadow[i*DATA_W +: DATA_W];
        w_hc  = r_hc[i];
      end
    end
    for (int k = 0; k < HEX_DIG; k++) begin
      if (w_col == 8'(3 + k)) w_nib = w_val[(HEX_DIG-1-k)*4 +: 4];
    end
    if (w_in_win) begin
      case (w_col)
        8'd0:    w_char = 7'h52;
        8'd1:    w_char = hex_ascii(w_row);
        8'd2:    w_char = 7'h3D;
        default: w_char = hex_ascii(w_nib);
      endcase
    end
  end

  // Only the digit cells highlight; the "R<i>=" label keeps the normal colour.
  assign w_hl = w_in_win && (w_hc != '0) && (w_col >= 8'd3);

  assign w_px = rom_data[3'd7 - r_bit[ROM_LAT]];

  // Pixel pipeline: stage 0 sits alongside the registered ROM address, the delay line
  // carries the side information until rom_data for that address arrives.
  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r_win      <= '0;
      r_hl       <= '0;
      r_von      <= '0;
      r_rgb      <= '0;
      for (int i = 0; i <= ROM_LAT; i++) r_bit[i] <= '0;
    end else begin
      r_rom_addr <= {w_char, w_dy[3:0]};
      r_bit[0]   <= w_dx[2:0];
      r_win[0]   <= w_in_win;
      r_hl[0]    <= w_hl;
      r_von[0]   <= video_on;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_bit[i] <= r_bit[i-1];
        r_win[i] <= r_win[i-1];
        r_hl[i]  <= r_hl[i-1];
        r_von[i] <= r_von[i-1];
      end
      if (!r_von[ROM_LAT])
        r_rgb <= 12'h000;
      else if (r_win[ROM_LAT] && w_px)
        r_rgb <= r_hl[ROM_LAT] ? HL_RGB : FG_RGB;
      else
        r_rgb <= BG_RGB;
    end
  end

  // Snapshot once per frame; highlight counters update the following cycle by comparing
  // the fresh snapshot with the one before it.
  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_prev   <= '0;
      r_snap_d <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_hc[i] <= '0;
    end else begin
      r_snap_d <= w_snap;
      if (w_snap) begin
        r_prev   <= r_shadow;
        r_shadow <= reg_flat;
      end
      if (r_snap_d) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_shadow[i*DATA_W +: DATA_W] != r_prev[i*DATA_W +: DATA_W])
            r_hc[i] <= HC_W'(HOLD_FRAMES);
          else if (r_hc[i] != '0)
            r_hc[i] <= r_hc[i] - HC_W'(1);
        end
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign rgb      = r_rgb;

endmodule

// File: tb/tb_hex_reg_overlay.sv
// tb/tb_hex_reg_overlay.sv - bench for hex_reg_overlay with a behavioural screen model
module tb_hex_reg_overlay;
  localparam int OX = 192, OY = 208, NR = 8, HEX = 2, COLS = 5, HOLD = 60;
  localparam logic [11:0] FG = 12'h00F, HL = 12'hF00, BG = 12'hFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         video_on = 1'b0;
  logic [9:0]   x = '0, y = '0;
  logic [63:0]  reg_flat = '0;
  logic [10:0]  rom_addr;
  logic [7:0]   rom_data = '0;
  logic [11:0]  rgb;
  logic [255:0] reg_flat16 = '0;
  logic [10:0]  rom_addr16;
  logic [7:0]   rom_data16 = '0;
  logic [11:0]  rgb16;

  int n_cmp = 0, n_fail = 0;
  int m_shadow [NR];
  int m_last [NR];
  int ev;
  logic [11:0] exp_q [$];

  always #5 clk = ~clk;

  hex_reg_overlay u_dut (
    .clkvga(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y),
    .reg_flat(reg_flat), .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb)
  );

  hex_reg_overlay #(.NUM_REGS(16), .DATA_W(16)) u_dut16 (
    .clkvga(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y),
    .reg_flat(reg_flat16), .rom_addr(rom_addr16), .rom_data(rom_data16), .rgb(rgb16)
  );

  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd73 + 16'(a >> 4);
    return t[7:0] ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    rom_data   <= rom_fn(rom_addr);
    rom_data16 <= rom_fn(rom_addr16);
  end

  function automatic logic [6:0] hexc(input int n);
    return (n < 10) ? 7'(48 + n) : 7'(65 + n - 10);
  endfunction

  // What the screen should show at (px,py) given the last snapshot and the frame count.
  task automatic model(input int px, input int py, input bit von,
                       output logic [11:0] e, output logic [10:0] ea);
    int dx, dy, col, row;
    bit inwin, hl, on;
    logic [6:0] ch;
    logic [7:0] g;
    dx = px - OX;
    dy = py - OY;
    inwin = (dx >= 0) && (dx < COLS * 8) && (dy >= 0) && (dy < NR * 16);
    ch = 7'h00;
    hl = 1'b0;
    if (inwin) begin
      col = dx / 8;
      row = dy / 16;
      if (col == 0) ch = 7'h52;
      else if (col == 1) ch = hexc(row);
      else if (col == 2) ch = 7'h3D;
      else begin
        ch = hexc((m_shadow[row] >> (4 * (HEX - 1 - (col - 3)))) & 15);
        hl = (ev - m_last[row]) < HOLD;
      end
    end
    ea = {ch, 4'(dy & 15)};
    g  = rom_fn(ea);
    on = inwin && g[7 - (dx & 7)];
    e  = !von ? 12'h000 : (on ? (hl ? HL : FG) : BG);
  endtask

  task automatic step(input int px, input int py, input bit von);
    logic [11:0] e;
    logic [10:0] ea;
    x = 10'(px);
    y = 10'(py);
    video_on = von;
    model(px, py, von, e, ea);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cmp++;
    if (rom_addr !== ea) begin
      n_fail++;
      $display("FAIL rom_addr x=%0d y=%0d: got %h want %h", px, py, rom_addr, ea);
    end
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rgb !== e) begin
        n_fail++;
        $display("FAIL rgb (pixel 2 steps before x=%0d y=%0d): got %h want %h", px, py, rgb, e);
      end
    end
  endtask

  task automatic snap();
    int v;
    step(0, 480, 1'b0);
    ev++;
    for (int i = 0; i < NR; i++) begin
      v = int'(reg_flat[i*8 +: 8]);
      if (v != m_shadow[i]) m_last[i] = ev;
      m_shadow[i] = v;
    end
    step(1, 480, 1'b0);
  endtask

  task automatic rand_frame(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(OX - 16, OX + COLS * 8 + 16), $urandom_range(OY - 8, OY + NR * 16 + 8),
           $urandom_range(0, 7) != 0);
    snap();
  endtask

  function automatic bit find_pix(input logic [6:0] ch, output int g, output int b);
    logic [7:0] d;
    for (int gi = 0; gi < 16; gi++) begin
      d = rom_fn({ch, 4'(gi)});
      for (int bi = 0; bi < 8; bi++) begin
        if (d[7 - bi]) begin
          g = gi;
          b = bi;
          return 1'b1;
        end
      end
    end
    g = 0;
    b = 0;
    return 1'b0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = 10'($urandom);
      y = 10'($urandom);
      video_on = 1'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if (rgb !== 12'h000 || rom_addr !== 11'h000) begin
        n_fail++;
        $display("FAIL reset_hold: got rgb=%h rom_addr=%h want 000/000", rgb, rom_addr);
      end
    end
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      m_shadow[i] = 0;
      m_last[i]   = -1000;
    end
    ev = 0;
    for (int i = 0; i < 3; i++) begin
      step(10, 10, 1'b1);
      n_cmp++;
      if (rgb !== ((i < 2) ? 12'h000 : BG)) begin
        n_fail++;
        $display("FAIL reset_latency step %0d: got %h want %h", i, rgb, (i < 2) ? 12'h000 : BG);
      end
    end
  endtask

  task automatic test_glyph();
    reg_flat = {$urandom, $urandom};
    reg_flat[23:16] = 8'hA5;
    snap();
    step(OX + 24, 245, 1'b1);
    n_cmp++;
    if (rom_addr !== {7'h41, 4'd5}) begin
      n_fail++;
      $display("FAIL glyph_col3: got %h want %h", rom_addr, {7'h41, 4'd5});
    end
    step(OX + 32, 245, 1'b1);
    n_cmp++;
    if (rom_addr !== {7'h35, 4'd5}) begin
      n_fail++;
      $display("FAIL glyph_col4: got %h want %h", rom_addr, {7'h35, 4'd5});
    end
    step(OX + 8, 245, 1'b1);
    n_cmp++;
    if (rom_addr !== {7'h32, 4'd5}) begin
      n_fail++;
      $display("FAIL glyph_col1: got %h want %h", rom_addr, {7'h32, 4'd5});
    end
    repeat (3) step(OX + COLS * 8, 245, 1'b1);
    n_cmp++;
    if (rgb !== BG) begin
      n_fail++;
      $display("FAIL right_edge_bg: got %h want %h", rgb, BG);
    end
    repeat (3) step(OX - 8, 245, 1'b1);
    n_cmp++;
    if (rgb !== BG) begin
      n_fail++;
      $display("FAIL left_of_window_bg: got %h want %h", rgb, BG);
    end
    for (int f = 0; f < 4; f++) begin
      reg_flat = {$urandom, $urandom};
      rand_frame(60);
    end
  endtask

  task automatic test_tearing();
    int old_v, new_v;
    reg_flat = {$urandom, $urandom};
    snap();
    rand_frame(30);
    old_v = m_shadow[5];
    new_v = old_v ^ 8'hFF;
    step(OX + 24, 300, 1'b1);
    reg_flat[47:40] = 8'(new_v);
    for (int i = 0; i < 30; i++)
      step($urandom_range(OX, OX + COLS * 8 - 1), $urandom_range(300, OY + NR * 16 - 1), 1'b1);
    step(OX + 24, 300, 1'b1);
    n_cmp++;
    if (rom_addr !== {hexc(old_v >> 4), 4'd12}) begin
      n_fail++;
      $display("FAIL tearing_before: got %h want %h", rom_addr, {hexc(old_v >> 4), 4'd12});
    end
    snap();
    step(OX + 24, 300, 1'b1);
    n_cmp++;
    if (rom_addr !== {hexc(new_v >> 4), 4'd12}) begin
      n_fail++;
      $display("FAIL tearing_after: got %h want %h", rom_addr, {hexc(new_v >> 4), 4'd12});
    end
  endtask

  // Frame f counts frames since the change of row 0; digits highlight while f < hl_frames.
  task automatic run_hold(input int nframes, input int hl_frames, input int base);
    int g, b;
    bit ok;
    for (int f = 0; f < nframes; f++) begin
      ok = find_pix(hexc(m_shadow[0] >> 4), g, b);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL hold_pixel_search: got none want a lit glyph bit");
      end
      repeat (3) step(OX + 24 + b, OY + g, 1'b1);
      n_cmp++;
      if (rgb !== ((f < hl_frames) ? HL : FG)) begin
        n_fail++;
        $display("FAIL hold_digit frame %0d: got %h want %h", base + f, rgb, (f < hl_frames) ? HL : FG);
      end
      ok = find_pix(7'h52, g, b);
      repeat (3) step(OX + b, OY + g, 1'b1);
      n_cmp++;
      if (!ok || rgb !== FG) begin
        n_fail++;
        $display("FAIL hold_label frame %0d: got %h want %h", base + f, rgb, FG);
      end
      rand_frame(6);
    end
  endtask

  task automatic test_highlight();
    reg_flat[7:0] = 8'h00;
    snap();
    reg_flat[7:0] = 8'h3C;
    snap();
    run_hold(62, 60, 0);
  endtask

  task automatic test_reload();
    reg_flat[7:0] = 8'hC3;
    snap();
    run_hold(30, 60, 0);
    reg_flat[7:0] = 8'h5A;
    snap();
    run_hold(62, 60, 30);
  endtask

  task automatic test_params();
    logic [6:0] e16 [7];
    e16 = '{7'h52, 7'h46, 7'h3D, 7'h42, 7'h45, 7'h45, 7'h46};
    reg_flat16 = {8{$urandom}};
    reg_flat16[15*16 +: 16] = 16'hBEEF;
    snap();
    for (int c = 0; c < 7; c++) begin
      step(OX + 8 * c + 1, 451, 1'b1);
      n_cmp++;
      if (rom_addr16 !== {e16[c], 4'd3}) begin
        n_fail++;
        $display("FAIL params_row15_col%0d: got %h want %h", c, rom_addr16, {e16[c], 4'd3});
      end
    end
    repeat (3) step(OX + 56, 451, 1'b1);
    n_cmp++;
    if (rgb16 !== BG) begin
      n_fail++;
      $display("FAIL params_right_edge: got %h want %h", rgb16, BG);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glyph();
    test_tearing();
    test_highlight();
    test_reload();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
